// File: rtl/argmax_classifier.sv
// Scans the final-layer logit BRAM after the MLP finishes and reports the index and value of the
// largest signed logit over a valid/ready handshake. Ties resolve to the lowest index.
module argmax_classifier #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned ADDR_WIDTH  = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  rden,
  output logic [ADDR_WIDTH-1:0] rdaddr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [ADDR_WIDTH-1:0] class_out,
  output logic [DATA_WIDTH-1:0] max_value,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {StIdle, StScan, StLast, StResult} state_e;

  state_e                  state_q;
  logic                    data_valid_q;
  logic [ADDR_WIDTH-1:0]   data_idx_q;
  logic [DATA_WIDTH-1:0]   best_val_q, best_val_d;
  logic [ADDR_WIDTH-1:0]   best_idx_q, best_idx_d;

  // Running best including the element currently on q, so the final compare can be folded
  // directly into the registered result on the edge that leaves StLast.
  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    if (data_valid_q &&
        ((data_idx_q == '0) || ($signed(q) > $signed(best_val_q)))) begin
      best_val_d = q;
      best_idx_d = data_idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      busy         <= 1'b0;
      rden         <= 1'b0;
      rdaddr       <= '0;
      class_out    <= '0;
      max_value    <= '0;
      result_valid <= 1'b0;
      data_valid_q <= 1'b0;
      data_idx_q   <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
    end else begin
      // q lags the address by one cycle, so the valid flag lags rden by one cycle.
      data_valid_q <= rden;
      if (data_valid_q) begin
        best_val_q <= best_val_d;
        best_idx_q <= best_idx_d;
        if (data_idx_q != LastIdx) begin
          data_idx_q <= data_idx_q + ADDR_WIDTH'(1);
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StScan;
            busy       <= 1'b1;
            rden       <= 1'b1;
            rdaddr     <= '0;
            data_idx_q <= '0;
          end
        end
        StScan: begin
          if (rdaddr == LastIdx) begin
            state_q <= StLast;
            rden    <= 1'b0;
            rdaddr  <= '0;
          end else begin
            rdaddr <= rdaddr + ADDR_WIDTH'(1);
          end
        end
        StLast: begin
          state_q      <= StResult;
          result_valid <= 1'b1;
          class_out    <= best_idx_d;
          max_value    <= best_val_d;
        end
        StResult: begin
          if (result_ready) begin
            state_q      <= StIdle;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
